// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES input stream: block geometry,
// end-of-block flag, serializer states and FIFO word field positions.
package aes_stream_pkg;

   localparam int unsigned AES_BLOCK_BYTES = 16;
   localparam logic [15:0] AES_LAST_FLAG   = 16'h1111;

   localparam int unsigned FLAG_MSB = 31;
   localparam int unsigned FLAG_LSB = 16;
   localparam int unsigned KEY_MSB  = 15;
   localparam int unsigned KEY_LSB  = 8;
   localparam int unsigned DATA_MSB = 7;
   localparam int unsigned DATA_LSB = 0;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

endpackage

// File: rtl/aes_block_serializer.sv
// Turns one 128-bit key/plaintext pair into 16 FIFO words,
// one key byte and one data byte per word, MSB first.
module aes_block_serializer
   import aes_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter logic [15:0] LAST_FLAG   = AES_LAST_FLAG,
   parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  blk_valid,
   output logic                  blk_ready,
   input  logic [127:0]          blk_key,
   input  logic [127:0]          blk_data,
   input  logic                  fifo_full,
   output logic                  fifo_wr,
   output logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  busy,
   output logic [15:0]           blk_count
);

   localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

   ser_state_e   state_q, state_d;
   logic [3:0]   idx_q, idx_d;
   logic [127:0] key_q, key_d;
   logic [127:0] data_q, data_d;
   logic [15:0]  cnt_q, cnt_d;

   logic         is_send;
   logic         last_w;
   logic [31:0]  word;

   assign is_send   = (state_q == SEND);
   assign last_w    = (idx_q == LAST_IDX);
   assign fifo_wr   = is_send & ~fifo_full;
   assign blk_ready = ~is_send;
   assign busy      = is_send;
   assign blk_count = cnt_q;

   always_comb begin
      word = '0;
      if (is_send) begin
         word[FLAG_MSB:FLAG_LSB] = last_w ? LAST_FLAG : 16'h0000;
         word[KEY_MSB:KEY_LSB]   = key_q[127:120];
         word[DATA_MSB:DATA_LSB] = data_q[127:120];
      end
   end

   // Bits above the 32-bit word are always zero.
   always_comb begin
      fifo_dout       = '0;
      fifo_dout[31:0] = word;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      key_d   = key_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (blk_valid) begin
               key_d   = blk_key;
               data_d  = blk_data;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         (state_q == SEND): begin
            if (fifo_wr) begin
               key_d  = {key_q[119:0], 8'h00};
               data_d = {data_q[119:0], 8'h00};
               idx_d  = idx_q + 4'd1;
               if (last_w) begin
                  state_d = IDLE;
                  cnt_d   = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         key_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: FIPS-197 vector,
// backpressure, reset mid-block, back-to-back and counter wrap.
module tb_aes_block_serializer;

   logic         clock;
   logic         reset_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] blk_key;
   logic [127:0] blk_data;
   logic         fifo_full;
   logic         fifo_wr;
   logic [31:0]  fifo_dout;
   logic         busy;
   logic [15:0]  blk_count;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;

   logic [31:0] fips_w [16] = '{
      32'h00000000, 32'h00000111, 32'h00000222, 32'h00000333,
      32'h00000444, 32'h00000555, 32'h00000666, 32'h00000777,
      32'h00000888, 32'h00000999, 32'h00000aaa, 32'h00000bbb,
      32'h00000ccc, 32'h00000ddd, 32'h00000eee, 32'h11110fff
   };

   aes_block_serializer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_key   (blk_key),
      .blk_data  (blk_data),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_dout (fifo_dout),
      .busy      (busy),
      .blk_count (blk_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Presents a block at a negedge; returns at the negedge after capture.
   task automatic start_block(input logic [127:0] k, input logic [127:0] d);
      @(negedge clock);
      blk_key   = k;
      blk_data  = d;
      blk_valid = 1'b1;
      @(negedge clock);
      blk_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      blk_valid = 1'b0;
      fifo_full = 1'b0;
      blk_key   = '0;
      blk_data  = '0;
      repeat (2) @(negedge clock);
      #1;
      n_chk++;
      if (fifo_wr !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: wr=%b busy=%b want 0 0", fifo_wr, busy);
      end
      n_chk++;
      if (blk_count !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_cnt: got %h want 0000", blk_count);
      end
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      n_chk++;
      if (blk_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 1", blk_ready);
      end
   endtask

   task automatic test_fips();
      start_block(K1, D1);
      #1;
      n_chk++;
      if (busy !== 1'b1 || blk_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fips_busy: busy=%b rdy=%b want 1 0", busy, blk_ready);
      end
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (fifo_wr !== 1'b1 || fifo_dout !== fips_w[i]) begin
            n_fail++;
            $display("FAIL fips_word%0d: wr=%b dout=%h want wr=1 dout=%h",
                     i, fifo_wr, fifo_dout, fips_w[i]);
         end
         @(negedge clock);
         #1;
      end
      n_chk++;
      if (blk_ready !== 1'b1 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fips_end: rdy=%b wr=%b busy=%b want 1 0 0",
                  blk_ready, fifo_wr, busy);
      end
      n_chk++;
      if (blk_count !== 16'd1) begin
         n_fail++;
         $display("FAIL fips_cnt: got %0d want 1", blk_count);
      end
   endtask

   task automatic test_stall(input int at, input int len,
                             input logic [15:0] cnt0);
      int idx;
      int stall;
      int cyc;
      idx   = 0;
      stall = 0;
      cyc   = 0;
      start_block(K1, D1);
      while (idx < 16 && cyc < 40) begin
         fifo_full = (idx == at) && (stall < len);
         #1;
         cyc++;
         n_chk++;
         if (fifo_full) begin
            stall++;
            if (fifo_wr !== 1'b0 || fifo_dout !== fips_w[at] ||
                blk_count !== cnt0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL stall%0d_hold: wr=%b dout=%h cnt=%0d busy=%b want 0 %h %0d 1",
                        at, fifo_wr, fifo_dout, blk_count, busy, fips_w[at], cnt0);
            end
         end else begin
            if (fifo_wr !== 1'b1 || fifo_dout !== fips_w[idx]) begin
               n_fail++;
               $display("FAIL stall%0d_word%0d: wr=%b dout=%h want 1 %h",
                        at, idx, fifo_wr, fifo_dout, fips_w[idx]);
            end
            idx++;
         end
         @(negedge clock);
      end
      fifo_full = 1'b0;
      #1;
      n_chk++;
      if (fifo_wr !== 1'b0 || blk_ready !== 1'b1 || blk_count !== cnt0 + 16'd1) begin
         n_fail++;
         $display("FAIL stall%0d_end: wr=%b rdy=%b cnt=%0d want 0 1 %0d",
                  at, fifo_wr, blk_ready, blk_count, cnt0 + 16'd1);
      end
   endtask

   task automatic test_back_to_back(input logic [15:0] cnt0);
      @(negedge clock);
      blk_key   = K1;
      blk_data  = D1;
      blk_valid = 1'b1;
      @(negedge clock);
      blk_key  = {16{8'hff}};
      blk_data = '0;
      #1;
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (fifo_wr !== 1'b1 || fifo_dout !== fips_w[i]) begin
            n_fail++;
            $display("FAIL b2b_a_word%0d: wr=%b dout=%h want 1 %h",
                     i, fifo_wr, fifo_dout, fips_w[i]);
         end
         @(negedge clock);
         #1;
      end
      n_chk++;
      if (fifo_wr !== 1'b0 || blk_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: wr=%b rdy=%b want 0 1", fifo_wr, blk_ready);
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         blk_valid = (i < 14) ? (i % 2 == 1) : 1'b0;
         #1;
         n_chk++;
         if (fifo_wr !== 1'b1 ||
             fifo_dout !== ((i == 15) ? 32'h1111ff00 : 32'h0000ff00)) begin
            n_fail++;
            $display("FAIL b2b_b_word%0d: wr=%b dout=%h", i, fifo_wr, fifo_dout);
         end
      end
      @(negedge clock);
      #1;
      n_chk++;
      if (blk_ready !== 1'b1 || blk_count !== cnt0 + 16'd2) begin
         n_fail++;
         $display("FAIL b2b_end: rdy=%b cnt=%0d want 1 %0d",
                  blk_ready, blk_count, cnt0 + 16'd2);
      end
      @(negedge clock);
      #1;
      n_chk++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: busy=%b wr=%b want 0 0", busy, fifo_wr);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      start_block(K1, D1);
      #1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         #1;
      end
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (fifo_wr !== 1'b0 || busy !== 1'b0 || blk_count !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_clear: wr=%b busy=%b cnt=%0d want 0 0 0",
                  fifo_wr, busy, blk_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      start_block(K1, D1);
      #1;
      n_chk++;
      if (fifo_wr !== 1'b1 || fifo_dout !== fips_w[0]) begin
         n_fail++;
         $display("FAIL rstmid_restart: wr=%b dout=%h want 1 %h",
                  fifo_wr, fifo_dout, fips_w[0]);
      end
      @(negedge clock);
      #1;
      n_chk++;
      if (fifo_dout !== fips_w[1]) begin
         n_fail++;
         $display("FAIL rstmid_word1: got %h want %h", fifo_dout, fips_w[1]);
      end
      cyc = 0;
      while (!blk_ready && cyc < 40) begin
         @(negedge clock);
         #1;
         cyc++;
      end
      n_chk++;
      if (blk_ready !== 1'b1 || blk_count !== 16'd1) begin
         n_fail++;
         $display("FAIL rstmid_done: rdy=%b cnt=%0d want 1 1", blk_ready, blk_count);
      end
   endtask

   task automatic test_wrap();
      int cyc;
      @(negedge clock);
      force dut.cnt_q = 16'hffff;
      @(posedge clock);
      #1;
      release dut.cnt_q;
      @(negedge clock);
      #1;
      n_chk++;
      if (blk_count !== 16'hffff) begin
         n_fail++;
         $display("FAIL wrap_preload: got %h want ffff", blk_count);
      end
      start_block(K1, D1);
      #1;
      cyc = 0;
      while (!blk_ready && cyc < 40) begin
         @(negedge clock);
         #1;
         cyc++;
      end
      n_chk++;
      if (blk_ready !== 1'b1 || blk_count !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_cnt: rdy=%b cnt=%h want 1 0000", blk_ready, blk_count);
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_stall(5, 3, 16'd1);
      test_stall(15, 5, 16'd2);
      test_back_to_back(16'd3);
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Upstream feeder for the AES user CL top.
- Accepts one 128-bit key and one 128-bit plaintext block per valid/ready handshake.
- Emits 16 words into the AES input FIFO, one byte of key and one byte of data per word, most significant byte first.
- The final word carries the end-of-block flag the AES core uses to start readout.

Parameters:
- DATA_WIDTH, 32, FIFO word width. Must be ≥32; bits above 31 are driven 0.
- LAST_FLAG, 16'h1111, value placed in dout[31:16] on the 16th word only.
- BLOCK_BYTES, 16, bytes per key/data block. Fixed at 16; other values are not supported.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  key/data block presented.
- blk_ready  out  1  serializer can accept a block.
- blk_key  in  128  AES key; bits [127:120] are sent first.
- blk_data  in  128  plaintext; bits [127:120] are sent first.
- fifo_full  in  1  input FIFO cannot accept a write this cycle.
- fifo_wr  out  1  write strobe to the input FIFO.
- fifo_dout  out  DATA_WIDTH  {flag16, key byte, data byte}.
- busy  out  1  block in progress.
- blk_count  out  16  blocks fully sent; wraps from 16'hFFFF to 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, byte index=0, key/data shift registers=0, blk_count=0.
  - fifo_wr=0, busy=0, blk_ready=1 once released.
- States: IDLE, SEND.
- IDLE:
  - blk_ready=1, fifo_wr=0.
  - On blk_valid && blk_ready at edge N: capture blk_key/blk_data into the shift registers, set index=0, go to SEND.
- SEND:
  - blk_ready=0, busy=1.
  - fifo_wr = !fifo_full (combinational from state and fifo_full).
  - fifo_dout[15:8] = key_sh[127:120].
  - fifo_dout[7:0] = data_sh[127:120].
  - fifo_dout[31:16] = LAST_FLAG when index==15, else 0.
  - fifo_dout is valid whenever the state is SEND, even while fifo_full=1.
- On an edge with fifo_wr=1: shift both registers left by 8 and increment index.
- On the write with index==15: return to IDLE and increment blk_count.
- Latency: first fifo_wr=1 in the cycle after the capture edge. With no backpressure, the 16 words go out on 16 consecutive cycles.
- Throughput: minimum 17 cycles per block, because there is one IDLE cycle between blocks.
- Backpressure: while fifo_full=1, fifo_wr=0 and fifo_dout holds its word. No word is dropped or duplicated. An arbitrary stall length is allowed, including on the last word.
- blk_valid during SEND is ignored; a held blk_valid is accepted on the next IDLE cycle.
- blk_key/blk_data may change after capture without affecting the block in flight.
- Reset mid-block: outputs clear immediately (asynchronously). The partial block is abandoned and never resumed, and blk_count is not incremented. The downstream FIFO and AES core are reset by the same reset_n.

Decomposition:
- Shared package aes_stream_pkg:
  - AES_BLOCK_BYTES=16
  - AES_LAST_FLAG=16'h1111
  - state enum {IDLE, SEND}
  - word field positions (FLAG_MSB/LSB, KEY_MSB/LSB, DATA_MSB/LSB)
- The downstream AES top and its testbenches import the same package.
- No sub-module: a single module is natural.

Test Plan:
- FIPS-197 vector: key 128'h000102030405060708090a0b0c0d0e0f, data 128'h00112233445566778899aabbccddeeff, fifo_full=0.
  - Expect 16 consecutive writes: 0x00000000, 0x00000111, 0x00000222 … 0x00000eee, 0x11110fff.
  - blk_count=1; blk_ready returns to 1 on the 17th cycle after capture.
- Backpressure: same vector, fifo_full=1 for 3 cycles while word 5 (0x00000555) is presented.
  - fifo_wr is low for those cycles and 0x00000555 is held.
  - Sequence is unchanged and the block completes in 19 cycles.
- Stall on last word: fifo_full=1 for 5 cycles at index 15.
  - 0x11110fff is held with fifo_wr=0, then written once.
  - blk_count increments only on that write.
- Reset mid-block: assert reset_n=0 after 7 words written.
  - fifo_wr=0 and busy=0 immediately, blk_count=0.
  - After release a new block starts from word 0.
- Back-to-back with blk_valid held high: two blocks, second block key all 0xFF and data all 0x00.
  - Second block's first word is 0x0000ff00, with exactly one idle cycle between blocks.
  - blk_valid pulses during SEND are ignored; blk_count=2.
- Wrap: preload blk_count to 16'hFFFF (via 65535 fast blocks or a force) and send one block → blk_count=0.
